misao_mem_bridge: RTL

- Memory-side stage directly below the MISA-O core.
- Turns the core's nibble-addressed, 4-bit accesses into byte-wide, handshaked accesses to external memory.
- Holds a one-byte line buffer, so the second nibble of a fetched byte is served without a new external access.
- Stalls the core by driving the core's read/write enable inputs.

---
 rtl/misao_mem_bridge.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/misao_mem_bridge.sv
// Nibble-to-byte memory bridge below the MISA-O core, with a one-byte line buffer.
// Optional ack timeout is enabled by defining MISAO_MEM_TIMEOUT_EN.
module misao_mem_bridge #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] core_addr,
  input  logic        core_rw,
  input  logic [3:0]  core_wdata,
  output logic [3:0]  core_rdata,
  output logic        core_en_read,
  output logic        core_en_write,
  output logic        ext_req,
  output logic        ext_we,
  output logic [14:0] ext_addr,
  output logic [7:0]  ext_wdata,
  output logic [1:0]  ext_wmask,
  input  logic        ext_ack,
  input  logic [7:0]  ext_rdata,
  output logic        err
);

  // Handshake: ext_req rises with ext_addr/ext_we/ext_wdata/ext_wmask stable and
  // they stay frozen until the single-cycle ext_ack; the core is held by en_* = 0.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_REQ = 2'd1,
    WR_REQ = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        buf_valid;
  logic [14:0] buf_tag;
  logic [7:0]  buf_byte;
  logic        tag_match;
  logic        timeout;

  assign tag_match = buf_valid && (buf_tag == core_addr[15:1]);

`ifdef MISAO_MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       err_q;

  assign timeout = (state != IDLE) && !ext_ack && (wait_cnt == WAIT_LIMIT);
  assign err     = err_q;

  // Counter sits at zero while idle, so every request starts counting from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
      err_q    <= 1'b0;
    end else if (state == IDLE) begin
      wait_cnt <= 8'd0;
    end else if (!ext_ack) begin
      if (timeout) begin
        err_q <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (!core_rw) begin
          next_state = WR_REQ;
        end else if (!tag_match) begin
          next_state = RD_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        if (ext_ack || timeout) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Core enables are Mealy outputs of IDLE and are forced low while in reset.
  always_comb begin
    core_en_read  = 1'b0;
    core_en_write = 1'b0;
    core_rdata    = 4'h0;
    if (rst && (state == IDLE)) begin
      core_en_read  = core_rw && tag_match;
      core_en_write = !core_rw;
      core_rdata    = core_addr[0] ? buf_byte[7:4] : buf_byte[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 15'd0;
      ext_wdata <= 8'd0;
      ext_wmask <= 2'b00;
      buf_valid <= 1'b0;
      buf_tag   <= 15'd0;
      buf_byte  <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!core_rw) begin
            ext_addr  <= core_addr[15:1];
            ext_wdata <= {core_wdata, core_wdata};
            ext_wmask <= core_addr[0] ? 2'b10 : 2'b01;
            ext_we    <= 1'b1;
            ext_req   <= 1'b1;
            // Write-through without allocate: only a resident byte is patched.
            if (tag_match) begin
              if (core_addr[0]) begin
                buf_byte[7:4] <= core_wdata;
              end else begin
                buf_byte[3:0] <= core_wdata;
              end
            end
          end else if (!tag_match) begin
            ext_addr <= core_addr[15:1];
            ext_we   <= 1'b0;
            ext_req  <= 1'b1;
          end
        end
        RD_REQ: begin
          if (ext_ack) begin
            buf_byte  <= ext_rdata;
            buf_tag   <= ext_addr;
            buf_valid <= 1'b1;
            ext_req   <= 1'b0;
          end else if (timeout) begin
            buf_byte  <= 8'hFF;
            buf_tag   <= ext_addr;
            buf_valid <= 1'b1;
            ext_req   <= 1'b0;
          end
        end
        WR_REQ: begin
          if (ext_ack || timeout) begin
            ext_req <= 1'b0;
            ext_we  <= 1'b0;
          end
        end
        default: ext_req <= 1'b0;
      endcase
    end
  end

endmodule
